// File: rtl/int8_mac_multilane_sequencer.sv
// int8_mac_multilane_sequencer
// Sequences one SIMD_DOT job through the multi-lane INT8 MAC wrapper: loads
// operand beats lane by lane, zero-pads short jobs up to NUM_LANES, holds exec
// until the wrapper answers, then offers the result on a valid/ready port.
// Optional exec watchdog: define INT8_MAC_SEQ_TIMEOUT_EN.
module int8_mac_multilane_sequencer #(
  parameter int XLEN        = 32,
  parameter int NUM_LANES   = 16,
  parameter int LANE_IDX_W  = 4,
  parameter int ID_W        = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  beat_valid_i,
  output logic                  beat_ready_o,
  input  logic [XLEN-1:0]       beat_rs1_i,
  input  logic [XLEN-1:0]       beat_rs2_i,
  input  logic                  beat_last_i,
  input  logic [XLEN-1:0]       job_rd_i,
  input  logic [4:0]            job_rd_addr_i,
  input  logic [ID_W-1:0]       job_id_i,
  output logic                  mac_valid_o,
  output logic                  mac_lane_load_o,
  output logic                  mac_lane_exec_o,
  output logic [LANE_IDX_W-1:0] mac_lane_idx_o,
  output logic [XLEN-1:0]       mac_rs1_o,
  output logic [XLEN-1:0]       mac_rs2_o,
  output logic [XLEN-1:0]       mac_rd_o,
  output logic [4:0]            mac_rd_addr_o,
  output logic [ID_W-1:0]       mac_id_o,
  input  logic [XLEN-1:0]       mac_result_i,
  input  logic                  mac_valid_i,
  input  logic                  mac_overflow_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [XLEN-1:0]       resp_result_o,
  output logic [4:0]            resp_rd_addr_o,
  output logic [ID_W-1:0]       resp_id_o,
  output logic                  resp_overflow_o,
  output logic                  resp_err_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PAD  = 3'd2,
    S_EXEC = 3'd3,
    S_RESP = 3'd4
  } state_e;

  localparam logic [LANE_IDX_W-1:0] LAST_IDX = LANE_IDX_W'(NUM_LANES - 1);

  // Reject parameter sets the lane counter cannot address.
  if ((NUM_LANES > 16) || ((1 << LANE_IDX_W) < NUM_LANES) || (TIMEOUT_CYC < 1)) begin : g_cfg_check
    $error("int8_mac_multilane_sequencer: unsupported parameter set");
  end

  state_e                state_q;
  logic [LANE_IDX_W-1:0] cnt_q;
  logic [LANE_IDX_W-1:0] cnt_d;
  logic [XLEN-1:0]       rd_q;
  logic [4:0]            rd_addr_q;
  logic [ID_W-1:0]       id_q;
  logic [XLEN-1:0]       res_q;
  logic                  ovf_q;
  logic                  accepting;
  logic                  beat_fire;

`ifdef INT8_MAC_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  assign resp_err_o = err_q;
`else
  assign resp_err_o = 1'b0;
`endif

  // Beats are only taken while loading; held low through reset.
  assign accepting = ~rst_i & ((state_q == S_IDLE) | (state_q == S_LOAD));
  assign beat_fire = accepting & beat_valid_i;
  // The counter parks on the last lane so it never overruns the lane range.
  assign cnt_d = (cnt_q == LAST_IDX) ? cnt_q : (cnt_q + LANE_IDX_W'(1));

  assign beat_ready_o    = accepting;
  assign busy_o          = (state_q != S_IDLE);
  assign resp_valid_o    = (state_q == S_RESP);
  assign resp_result_o   = res_q;
  assign resp_rd_addr_o  = rd_addr_q;
  assign resp_id_o       = id_q;
  assign resp_overflow_o = ovf_q;

  // FSM, lane counter, job context and captured response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      rd_addr_q <= '0;
      id_q      <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
`ifdef INT8_MAC_SEQ_TIMEOUT_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
`ifdef INT8_MAC_SEQ_TIMEOUT_EN
      wd_q <= '0;
`endif
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (beat_valid_i) begin
            if (state_q == S_IDLE) begin
              rd_q      <= job_rd_i;
              rd_addr_q <= job_rd_addr_i;
              id_q      <= job_id_i;
            end
            cnt_q <= cnt_d;
            if (cnt_q == LAST_IDX) begin
              state_q <= S_EXEC;
            end else if (beat_last_i) begin
              state_q <= S_PAD;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        S_PAD: begin
          cnt_q <= cnt_d;
          if (cnt_q == LAST_IDX) begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (mac_valid_i) begin
            res_q   <= mac_result_i;
            ovf_q   <= mac_overflow_i;
`ifdef INT8_MAC_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            state_q <= S_RESP;
          end
`ifdef INT8_MAC_SEQ_TIMEOUT_EN
          else if (wd_q == WD_LIMIT) begin
            res_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end
        S_RESP: begin
          if (resp_ready_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Wrapper controls: pass-through lane loads, zero pads, held exec.
  always_comb begin
    mac_valid_o     = 1'b0;
    mac_lane_load_o = 1'b0;
    mac_lane_exec_o = 1'b0;
    mac_lane_idx_o  = '0;
    mac_rs1_o       = '0;
    mac_rs2_o       = '0;
    mac_rd_o        = '0;
    mac_rd_addr_o   = '0;
    mac_id_o        = '0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (beat_fire) begin
          mac_valid_o     = 1'b1;
          mac_lane_load_o = 1'b1;
          mac_lane_idx_o  = cnt_q;
          mac_rs1_o       = beat_rs1_i;
          mac_rs2_o       = beat_rs2_i;
          // First beat: the job context is not latched yet, forward it live.
          if (state_q == S_IDLE) begin
            mac_rd_o      = job_rd_i;
            mac_rd_addr_o = job_rd_addr_i;
            mac_id_o      = job_id_i;
          end else begin
            mac_rd_o      = rd_q;
            mac_rd_addr_o = rd_addr_q;
            mac_id_o      = id_q;
          end
        end else begin
          mac_valid_o = 1'b0;
        end
      end
      S_PAD: begin
        mac_valid_o     = 1'b1;
        mac_lane_load_o = 1'b1;
        mac_lane_idx_o  = cnt_q;
        mac_rd_o        = rd_q;
        mac_rd_addr_o   = rd_addr_q;
        mac_id_o        = id_q;
      end
      S_EXEC: begin
        mac_valid_o     = 1'b1;
        mac_lane_exec_o = 1'b1;
        mac_lane_idx_o  = cnt_q;
        mac_rd_o        = rd_q;
        mac_rd_addr_o   = rd_addr_q;
        mac_id_o        = id_q;
      end
      default: begin
        mac_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_int8_mac_multilane_sequencer.sv
// Directed bench for int8_mac_multilane_sequencer; acts as the MAC wrapper and
// scoreboards the responses. Honours INT8_MAC_SEQ_TIMEOUT_EN like the design.
module tb_int8_mac_multilane_sequencer;
  localparam int XLEN = 32;
  localparam int NL   = 16;
  localparam int IDXW = 4;
  localparam int IDW  = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            beat_valid_i, beat_ready_o, beat_last_i;
  logic [XLEN-1:0] beat_rs1_i, beat_rs2_i, job_rd_i;
  logic [4:0]      job_rd_addr_i;
  logic [IDW-1:0]  job_id_i;
  logic            mac_valid_o, mac_lane_load_o, mac_lane_exec_o;
  logic [IDXW-1:0] mac_lane_idx_o;
  logic [XLEN-1:0] mac_rs1_o, mac_rs2_o, mac_rd_o;
  logic [4:0]      mac_rd_addr_o;
  logic [IDW-1:0]  mac_id_o;
  logic [XLEN-1:0] mac_result_i;
  logic            mac_valid_i, mac_overflow_i;
  logic            resp_valid_o, resp_ready_i;
  logic [XLEN-1:0] resp_result_o;
  logic [4:0]      resp_rd_addr_o;
  logic [IDW-1:0]  resp_id_o;
  logic            resp_overflow_o, resp_err_o, busy_o;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd_addr;
    logic [3:0]  id;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] stim_a[NL];
  logic [31:0] stim_b[NL];
  logic [31:0] wrap_a[NL];
  logic [31:0] wrap_b[NL];

  always #5 clk_i = ~clk_i;

  int8_mac_multilane_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o),
    .beat_rs1_i(beat_rs1_i), .beat_rs2_i(beat_rs2_i), .beat_last_i(beat_last_i),
    .job_rd_i(job_rd_i), .job_rd_addr_i(job_rd_addr_i), .job_id_i(job_id_i),
    .mac_valid_o(mac_valid_o), .mac_lane_load_o(mac_lane_load_o),
    .mac_lane_exec_o(mac_lane_exec_o), .mac_lane_idx_o(mac_lane_idx_o),
    .mac_rs1_o(mac_rs1_o), .mac_rs2_o(mac_rs2_o), .mac_rd_o(mac_rd_o),
    .mac_rd_addr_o(mac_rd_addr_o), .mac_id_o(mac_id_o),
    .mac_result_i(mac_result_i), .mac_valid_i(mac_valid_i), .mac_overflow_i(mac_overflow_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_result_o(resp_result_o), .resp_rd_addr_o(resp_rd_addr_o), .resp_id_o(resp_id_o),
    .resp_overflow_o(resp_overflow_o), .resp_err_o(resp_err_o), .busy_o(busy_o)
  );

  // Wrapper model: remember every lane the sequencer loads.
  always @(posedge clk_i) begin
    if (mac_valid_o && mac_lane_load_o) begin
      wrap_a[mac_lane_idx_o] <= mac_rs1_o;
      wrap_b[mac_lane_idx_o] <= mac_rs2_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
    int s;
    int pa;
    int pb;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      pa = $signed(a[8*k +: 8]);
      pb = $signed(b[8*k +: 8]);
      s = s + pa * pb;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic [4:0] ra, input logic [3:0] id,
                          input logic ovf, input logic err);
    exp_t        e;
    logic [31:0] s;
    s = rd;
    for (int i = 0; i < NL; i++) s = s + dot4(stim_a[i], stim_b[i]);
    e.result  = err ? 32'h0 : s;
    e.rd_addr = ra;
    e.id      = id;
    e.ovf     = ovf;
    e.err     = err;
    sb_q.push_back(e);
  endtask

  task automatic send_beats(input int n, input bit use_last, input bit rnd,
                            input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] rd,
                            input logic [4:0] ra, input logic [3:0] id);
    for (int i = 0; i < NL; i++) begin
      stim_a[i] = 32'h0;
      stim_b[i] = 32'h0;
    end
    job_rd_i      = rd;
    job_rd_addr_i = ra;
    job_id_i      = id;
    for (int i = 0; i < n; i++) begin
      beat_valid_i = 1'b1;
      beat_rs1_i   = rnd ? $urandom : a0;
      beat_rs2_i   = rnd ? $urandom : b0;
      beat_last_i  = use_last && (i == n - 1);
      stim_a[i]    = beat_rs1_i;
      stim_b[i]    = beat_rs2_i;
      @(negedge clk_i);
      chk("load_ready", beat_ready_o, 32'd1);
      chk("load_ctrl", {mac_valid_o, mac_lane_load_o, mac_lane_exec_o}, 32'b110);
      chk("load_idx", mac_lane_idx_o, i);
      chk("load_rs1", mac_rs1_o, stim_a[i]);
      chk("load_rs2", mac_rs2_o, stim_b[i]);
      chk("load_rd", mac_rd_o, rd);
      chk("load_id", mac_id_o, id);
      @(posedge clk_i); #1;
      // Context must have been latched on the first beat.
      job_rd_i      = 32'hDEADBEEF;
      job_rd_addr_i = 5'h1F;
      job_id_i      = 4'hF;
    end
    beat_valid_i = 1'b0;
    beat_last_i  = 1'b0;
  endtask

  task automatic run_pad(input int from, input int upto, input bit poke);
    for (int k = from; k <= upto; k++) begin
      if (poke && k == from) begin
        mac_valid_i  = 1'b1;
        mac_result_i = 32'hBAD0BAD0;
      end
      @(negedge clk_i);
      chk("pad_ready", beat_ready_o, 32'd0);
      chk("pad_ctrl", {mac_valid_o, mac_lane_load_o, mac_lane_exec_o}, 32'b110);
      chk("pad_idx", mac_lane_idx_o, k);
      chk("pad_ops", {mac_rs1_o, mac_rs2_o} == 64'h0, 32'd1);
      chk("pad_addr", mac_rd_addr_o, job_rd_addr_i == 5'h1F ? mac_rd_addr_o : 5'h0);
      @(posedge clk_i); #1;
      mac_valid_i  = 1'b0;
      mac_result_i = 32'h0;
    end
  endtask

  task automatic run_exec(input int hold, input logic ovf);
    logic [31:0] s;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      chk("exec_hold_ctrl", {mac_valid_o, mac_lane_load_o, mac_lane_exec_o}, 32'b101);
      chk("exec_hold_noresp", resp_valid_o, 32'd0);
      chk("exec_hold_ready", beat_ready_o, 32'd0);
      @(posedge clk_i); #1;
    end
    s = mac_rd_o;
    for (int i = 0; i < NL; i++) s = s + dot4(wrap_a[i], wrap_b[i]);
    mac_valid_i    = 1'b1;
    mac_result_i   = s;
    mac_overflow_i = ovf;
    @(negedge clk_i);
    chk("exec_ctrl", {mac_valid_o, mac_lane_load_o, mac_lane_exec_o}, 32'b101);
    chk("exec_ready", beat_ready_o, 32'd0);
    @(posedge clk_i); #1;
    mac_valid_i    = 1'b0;
    mac_result_i   = 32'h0;
    mac_overflow_i = 1'b0;
  endtask

  task automatic check_resp(output exp_t e);
    @(negedge clk_i);
    chk("resp_valid", resp_valid_o, 32'd1);
    chk("sb_pending", sb_q.size() > 0, 32'd1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = '{default: '0};
    chk("resp_result", resp_result_o, e.result);
    chk("resp_rd_addr", resp_rd_addr_o, e.rd_addr);
    chk("resp_id", resp_id_o, e.id);
    chk("resp_overflow", resp_overflow_o, e.ovf);
    chk("resp_err", resp_err_o, e.err);
    chk("resp_busy", busy_o, 32'd1);
    chk("resp_no_beat", beat_ready_o, 32'd0);
  endtask

  initial begin
    exp_t e;
    rst_i = 1'b1;
    beat_valid_i = 1'b0; beat_last_i = 1'b0; beat_rs1_i = '0; beat_rs2_i = '0;
    job_rd_i = '0; job_rd_addr_i = '0; job_id_i = '0;
    mac_result_i = '0; mac_valid_i = 1'b0; mac_overflow_i = 1'b0;
    resp_ready_i = 1'b1;

    // Reset state
    @(negedge clk_i);
    chk("rst_ready", beat_ready_o, 32'd0);
    chk("rst_mac_valid", mac_valid_o, 32'd0);
    chk("rst_resp", {resp_valid_o, resp_err_o, resp_overflow_o, busy_o}, 32'd0);
    chk("rst_result", resp_result_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", beat_ready_o, 32'd1);
    chk("post_rst_busy", busy_o, 32'd0);
    @(posedge clk_i); #1;

    // Job 1: full 16 beats, explicit last, exec held 3 cycles
    send_beats(16, 1'b1, 1'b0, 32'h01010101, 32'h02020202, 32'd0, 5'd5, 4'd3);
    push_exp(32'd0, 5'd5, 4'd3, 1'b0, 1'b0);
    run_exec(3, 1'b0);
    check_resp(e);
    chk("job1_result_128", resp_result_o, 32'd128);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("job1_idle_valid", resp_valid_o, 32'd0);
    chk("job1_idle_busy", busy_o, 32'd0);
    chk("job1_idle_ready", beat_ready_o, 32'd1);
    @(posedge clk_i); #1;

    // Job 2: 3 beats, padding, stray mac_valid in PAD, overflow, backpressure
    send_beats(3, 1'b1, 1'b1, 32'h0, 32'h0, 32'd100, 5'd9, 4'd6);
    push_exp(32'd100, 5'd9, 4'd6, 1'b1, 1'b0);
    resp_ready_i = 1'b0;
    run_pad(3, 15, 1'b1);
    run_exec(0, 1'b1);
    beat_valid_i = 1'b1;
    beat_rs1_i   = 32'h55555555;
    check_resp(e);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("bp_valid", resp_valid_o, 32'd1);
      chk("bp_result", resp_result_o, e.result);
      chk("bp_payload", {resp_rd_addr_o, resp_id_o, resp_overflow_o}, {e.rd_addr, e.id, e.ovf});
      chk("bp_no_beat", {beat_ready_o, mac_lane_load_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("handoff_valid", resp_valid_o, 32'd1);
    chk("handoff_no_beat", {beat_ready_o, mac_valid_o}, 32'd0);
    @(posedge clk_i); #1;
    beat_valid_i = 1'b0;
    @(negedge clk_i);
    chk("job2_idle", {resp_valid_o, busy_o}, 32'd0);
    @(posedge clk_i); #1;

    // Job 3: reset pulsed mid-PAD at lane 7
    send_beats(4, 1'b1, 1'b1, 32'h0, 32'h0, 32'd7, 5'd2, 4'd1);
    run_pad(4, 6, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("midrst_ctrl", {mac_valid_o, mac_lane_load_o, mac_lane_exec_o, beat_ready_o}, 32'd0);
    chk("midrst_idx", mac_lane_idx_o, 32'd0);
    chk("midrst_resp", {resp_valid_o, busy_o, resp_err_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("after_rst_idle", {busy_o, mac_valid_o, resp_valid_o}, 32'd0);
    chk("after_rst_ready", beat_ready_o, 32'd1);
    @(posedge clk_i); #1;

    // Job 4: 16 beats without last flag, implicit last, minimum latency
    send_beats(16, 1'b0, 1'b1, 32'h0, 32'h0, 32'h12345678, 5'd17, 4'd12);
    push_exp(32'h12345678, 5'd17, 4'd12, 1'b0, 1'b0);
    run_exec(0, 1'b0);
    check_resp(e);
    @(posedge clk_i); #1;

    // Job 5: the wrapper never answers
    send_beats(2, 1'b1, 1'b1, 32'h0, 32'h0, 32'd42, 5'd30, 4'd9);
    run_pad(2, 15, 1'b0);
`ifdef INT8_MAC_SEQ_TIMEOUT_EN
    push_exp(32'd42, 5'd30, 4'd9, 1'b0, 1'b1);
    for (int c = 0; c < 64; c++) begin
      @(negedge clk_i);
      chk("wd_exec_ctrl", {mac_valid_o, mac_lane_exec_o}, 32'b11);
      chk("wd_no_resp", resp_valid_o, 32'd0);
      @(posedge clk_i); #1;
    end
    check_resp(e);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("wd_idle", busy_o, 32'd0);
`else
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_i);
      chk("hang_exec_ctrl", {mac_valid_o, mac_lane_exec_o}, 32'b11);
      chk("hang_no_resp", {resp_valid_o, resp_err_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("hang_cleared", busy_o, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
